// File: rtl/adder_full.sv
// Single-bit full adder: combinational path plus a registered path with valid and
// bit-serial carry chaining. Define ADDER_FULL_STATS_EN to enable saturating op/carry counters.
module adder_full #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c_in,
   output logic             sum,
   output logic             c_out,
   input  logic             in_valid,
   input  logic             ser_en,
   output logic             sum_q,
   output logic             c_out_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] op_cnt,
   output logic [CNT_W-1:0] carry_cnt
);

   logic cin_eff;
   logic sum_nxt;
   logic cout_nxt;

   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (a & c_in) | (b & c_in);

   // In serial mode the stored carry replaces c_in, so the chain survives idle cycles.
   always_comb begin
      cin_eff  = ser_en ? c_out_q : c_in;
      sum_nxt  = a ^ b ^ cin_eff;
      cout_nxt = (a & b) | (a & cin_eff) | (b & cin_eff);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q     <= 1'b0;
         c_out_q   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum_q   <= sum_nxt;
            c_out_q <= cout_nxt;
         end
      end
   end

`ifdef ADDER_FULL_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_cnt    <= '0;
         carry_cnt <= '0;
      end else if (in_valid) begin
         if (op_cnt != '1) op_cnt <= op_cnt + 1'b1;
         if (cout_nxt && (carry_cnt != '1)) carry_cnt <= carry_cnt + 1'b1;
      end
   end
`else
   assign op_cnt    = '0;
   assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_adder_full.sv
// Directed self-checking bench for adder_full (CNT_W=2); expectations follow ADDER_FULL_STATS_EN.
module tb_adder_full;

`ifdef ADDER_FULL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       a = 1'b0, b = 1'b0, c_in = 1'b0, in_valid = 1'b0, ser_en = 1'b0;
   logic       sum, c_out, sum_q, c_out_q, out_valid;
   logic [1:0] op_cnt, carry_cnt;

   int checks = 0;
   int errors = 0;

   adder_full #(.CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in),
      .sum(sum), .c_out(c_out), .in_valid(in_valid), .ser_en(ser_en),
      .sum_q(sum_q), .c_out_q(c_out_q), .out_valid(out_valid),
      .op_cnt(op_cnt), .carry_cnt(carry_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive on the falling edge, then sample 1 time unit after the next rising edge.
   task automatic issue(input logic ta, input logic tb_, input logic tc,
                        input logic tv, input logic ts);
      @(negedge clk);
      a = ta; b = tb_; c_in = tc; in_valid = tv; ser_en = ts;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reg(input string tag, input logic es, input logic ec, input logic ev);
      check({tag, ".sum_q"}, 16'(sum_q), 16'(es));
      check({tag, ".c_out_q"}, 16'(c_out_q), 16'(ec));
      check({tag, ".out_valid"}, 16'(out_valid), 16'(ev));
   endtask

   task automatic check_cnt(input string tag, input int eo, input int ec);
      check({tag, ".op_cnt"}, 16'(op_cnt), STATS ? 16'(eo) : 16'd0);
      check({tag, ".carry_cnt"}, 16'(carry_cnt), STATS ? 16'(ec) : 16'd0);
   endtask

   // a, b of 0b0111 + 0b0011 LSB first, with expected sum_q / c_out_q per bit
   logic [3:0] sa = 4'b0111, sb = 4'b0011, es = 4'b1010, ec = 4'b0111;

   initial begin
      #1;
      check_reg("reset", 1'b0, 1'b0, 1'b0);
      check_cnt("reset", 0, 0);

      a = 0; b = 1; c_in = 1;
      #1;
      check("comb011.sum", 16'(sum), 16'd0);
      check("comb011.c_out", 16'(c_out), 16'd1);
      #40;
      check("comb011_hold", 16'({c_out, sum}), 16'b10);
      a = 1; b = 0; c_in = 1;
      #1;
      check("comb101", 16'({c_out, sum}), 16'b10);

      for (int i = 0; i < 8; i++) begin
         {a, b, c_in} = 3'(i);
         #1;
         check($sformatf("comb_all%0d", i), 16'({c_out, sum}),
               16'(32'(i[2]) + 32'(i[1]) + 32'(i[0])));
      end

      @(negedge clk);
      rst_n = 1'b1;
      issue(1, 1, 0, 1, 0);
      check_reg("reg110", 1'b0, 1'b1, 1'b1);
      check_cnt("reg110", 1, 1);
      issue(0, 0, 1, 0, 0);
      check_reg("reg_idle", 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 4; i++) begin
         issue(sa[i], sb[i], 1'b0, 1'b1, i != 0);
         check_reg($sformatf("ser_bit%0d", i), es[i], ec[i], 1'b1);
         if (i == 1) begin
            issue(1, 1, 1, 0, 1);
            check_reg("ser_idle", es[1], ec[1], 1'b0);
         end
      end
      check_cnt("ser_end", 3, 3);

      issue(1, 1, 0, 1, 0);
      check("pre_rst.c_out_q", 16'(c_out_q), 16'd1);
      #2 rst_n = 1'b0;
      #1;
      check_reg("async_rst", 1'b0, 1'b0, 1'b0);
      check_cnt("async_rst", 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      a = 1; b = 0; c_in = 1; in_valid = 1; ser_en = 1;
      @(posedge clk);
      #1;
      check_reg("post_rst_ser", 1'b1, 1'b0, 1'b1);
      check_cnt("post_rst_ser", 1, 0);

      @(negedge clk);
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         issue(1, 1, 0, 1, 0);
         check_cnt($sformatf("sat%0d", i), (i < 2) ? i + 1 : 3, (i < 2) ? i + 1 : 3);
      end
      issue(0, 0, 0, 0, 0);
      check_cnt("sat_idle", 3, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish before 100000");
      $fatal(1);
   end

endmodule

// File: doc/adder_full.md
Name: adder_full

Overview:
- Single-bit full adder with a zero-latency combinational path and a one-cycle registered path.
- The registered path has a valid handshake and an optional bit-serial carry-chaining mode (carry fed back from the previous registered result), so wide operands can be added LSB-first one bit per cycle.
- Used as the leaf arithmetic cell in datapath and serial-arithmetic blocks.

Parameters:
- CNT_W, 16, width of the statistics counters (used only when ADDER_FULL_STATS_EN is defined).

Ports:
- clk  input  1  rising-edge clock for the registered path
- rst_n  input  1  asynchronous active-low reset
- a  input  1  addend bit
- b  input  1  addend bit
- c_in  input  1  carry-in bit
- sum  output  1  combinational sum
- c_out  output  1  combinational carry-out
- in_valid  input  1  qualifies a, b, c_in for the registered path
- ser_en  input  1  1 = serial mode: the registered path uses its stored carry instead of c_in
- sum_q  output  1  registered sum
- c_out_q  output  1  registered carry-out, also the serial carry state
- out_valid  output  1  sum_q/c_out_q updated on the previous edge
- op_cnt  output  CNT_W  accepted-operation count (STATS only)
- carry_cnt  output  CNT_W  count of accepted operations with carry-out = 1 (STATS only)

Behaviour:
- Combinational path:
  - sum = a XOR b XOR c_in.
  - c_out = (a AND b) OR (a AND c_in) OR (b AND c_in).
  - Zero latency; independent of clk, rst_n, in_valid and ser_en.
- Effective carry for the registered path: cin_eff = ser_en ? c_out_q : c_in.
- On a rising clk edge with in_valid=1:
  - sum_q <= a XOR b XOR cin_eff.
  - c_out_q <= majority(a, b, cin_eff).
  - out_valid <= 1.
- On a rising clk edge with in_valid=0:
  - sum_q and c_out_q hold their values.
  - out_valid <= 0.
  - A serial chain survives idle cycles.
- out_valid is a one-cycle pulse per accepted input. Back-to-back valids give back-to-back pulses. There is no backpressure.
- Serial sequence start: the first bit is issued with ser_en=0 so that c_in seeds the chain. All following bits are issued with ser_en=1.
- ser_en=1 directly after reset chains from c_out_q=0.
- Reset (rst_n=0, asynchronous, takes effect immediately): sum_q=0, c_out_q=0, out_valid=0, op_cnt=0, carry_cnt=0.
  - Reset mid-chain discards the chain.
  - The combinational outputs still follow the inputs during reset.
  - Release is synchronous to the next edge: the first edge with rst_n=1 may accept an input.
- X-free: every registered output has a defined reset value.

Optional Feature:
- Macro ADDER_FULL_STATS_EN.
- Defined:
  - op_cnt increments on every accepted input (in_valid=1 at the edge).
  - carry_cnt increments when that accepted operation produces carry-out 1.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
  - Both reset to 0.
- Undefined: the op_cnt and carry_cnt ports still exist but are tied to 0, with no counter logic.

Test Plan:
- Combinational: a=0,b=1,c_in=1 -> sum=0, c_out=1 immediately; hold 40 time units, outputs stable. Then a=1,b=0,c_in=1 -> sum=0, c_out=1.
- Exhaustive combinational: all 8 input combinations -> {c_out,sum} = a+b+c_in (e.g. 1,1,1 -> 1,1; 0,0,0 -> 0,0; 1,0,0 -> 0,1).
- Registered: in_valid=1 with a=1,b=1,c_in=0 for one edge -> next cycle sum_q=0, c_out_q=1, out_valid=1. In_valid low on the following edge -> out_valid=0, sum_q/c_out_q held.
- Serial add 0b0111+0b0011, LSB first:
  - Bit 0 issued with ser_en=0, c_in=0; bits 1-3 with ser_en=1.
  - Required sum_q sequence 0,1,0,1 (=0b1010) and final c_out_q=0.
- Async reset: assert rst_n=0 between edges while c_out_q=1 -> sum_q, c_out_q and out_valid go to 0 immediately. Next edge after release with ser_en=1, a=1,b=0 -> sum_q=1, c_out_q=0.
- Stats (ADDER_FULL_STATS_EN defined, CNT_W=2): 5 accepted ops, all carry-producing -> op_cnt=3 and carry_cnt=3 (saturated). Without the macro, both read 0 throughout.
